// File: rtl/rotating_xbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rotating_xbar_pkg : index helpers shared by the rotating crossbar    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rotating_xbar_pkg;

  localparam int c_min_ports = 2;

  function automatic bit is_pow2(input int n);
    return (n >= c_min_ports) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int wrap_index(input int idx, input int n);
    return idx % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotating_xbar_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rotating_xbar_stage : one log2 barrel stage, rotates by SHIFT words  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rotating_xbar_stage
  import rotating_xbar_pkg::*;
#(
  parameter int NUM_DATA   = 4,
  parameter int DATA_WIDTH = 4,
  parameter int SHIFT      = 1
) (
  input  logic                                i_sel_bit,
  input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] i_data,
  output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] o_data
);

  for (genvar j = 0; j < NUM_DATA; j++) begin : g_word
    localparam int c_src = wrap_index(j + SHIFT, NUM_DATA);
    assign o_data[j] = i_sel_bit ? i_data[c_src] : i_data[j];
  end

endmodule
`default_nettype wire

// File: rtl/rotating_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rotating_xbar : N-port barrel rotator, out[j] = in[(sel+j) mod N]    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rotating_xbar
  import rotating_xbar_pkg::*;
#(
  parameter int NUM_DATA   = 4,
  parameter int DATA_WIDTH = 4,
  parameter int REG_OUT    = 0
) (
  input  logic                                clk_i,
  input  logic                                arst_ni,
  input  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] input_vector_i,
  input  logic [$clog2(NUM_DATA)-1:0]         start_select_i,
  output logic [NUM_DATA-1:0][DATA_WIDTH-1:0] output_vector_o
);

  localparam int c_sel_w = $clog2(NUM_DATA);

  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] w_rot;

  if (is_pow2(NUM_DATA)) begin : g_barrel
    // Stage k rotates by 2^k words; composing stages sums the shifts mod N.
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0] w_chain [c_sel_w+1];

    assign w_chain[0] = input_vector_i;

    for (genvar k = 0; k < c_sel_w; k++) begin : g_stage
      rotating_xbar_stage #(
        .NUM_DATA   (NUM_DATA),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (1 << k)
      ) u_stage (
        .i_sel_bit (start_select_i[k]),
        .i_data    (w_chain[k]),
        .o_data    (w_chain[k+1])
      );
    end

    assign w_rot = w_chain[c_sel_w];
  end else begin : g_mux
    // One extra bit keeps sel + j from overflowing before the wrap.
    localparam int c_idx_w = c_sel_w + 1;
    localparam logic [c_idx_w-1:0] c_num = c_idx_w'(NUM_DATA);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [c_idx_w-1:0] w_sel_ext;
    logic [c_idx_w-1:0] w_sel_red;

    assign w_sel_ext = {1'b0, start_select_i};
    // Select range is below 2*N, so one conditional subtract is a full modulo.
    assign w_sel_red = (w_sel_ext >= c_num) ? (w_sel_ext - c_num) : w_sel_ext;

    for (genvar j = 0; j < NUM_DATA; j++) begin : g_port
      logic [c_idx_w-1:0] w_sum;
      logic [c_idx_w-1:0] w_idx;
      word_t              w_word;

      assign w_sum = w_sel_red + c_idx_w'(j);
      assign w_idx = (w_sum >= c_num) ? (w_sum - c_num) : w_sum;

      always_comb begin
        w_word = {DATA_WIDTH{1'bx}};
        for (int i = 0; i < NUM_DATA; i++) begin
          if (w_idx == c_idx_w'(i)) begin
            w_word = input_vector_i[i];
          end
        end
      end

      assign w_rot[j] = w_word;
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0] r_out;

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        r_out <= '0;
      end else begin
        r_out <= w_rot;
      end
    end

    assign output_vector_o = r_out;
  end else begin : g_comb_out
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk_i ^ arst_ni;
    assign output_vector_o  = w_rot;
  end

endmodule
`default_nettype wire

// File: tb/tb_rotating_xbar.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rotating_xbar : directed and soak checks for three configurations |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rotating_xbar;

  logic clk    = 1'b0;
  logic arst_n = 1'b1;

  always #5 clk = ~clk;

  // N=4 combinational
  logic [15:0] in4;
  logic [1:0]  sel4;
  logic [15:0] out4;
  // N=3 combinational
  logic [11:0] in3;
  logic [1:0]  sel3;
  logic [11:0] out3;
  // N=4 registered
  logic [15:0] inr;
  logic [1:0]  selr;
  logic [15:0] outr;

  int checks = 0;
  int errors = 0;

  rotating_xbar #(.NUM_DATA(4), .DATA_WIDTH(4), .REG_OUT(0)) dut4 (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .input_vector_i  (in4),
    .start_select_i  (sel4),
    .output_vector_o (out4)
  );

  rotating_xbar #(.NUM_DATA(3), .DATA_WIDTH(4), .REG_OUT(0)) dut3 (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .input_vector_i  (in3),
    .start_select_i  (sel3),
    .output_vector_o (out3)
  );

  rotating_xbar #(.NUM_DATA(4), .DATA_WIDTH(4), .REG_OUT(1)) dutr (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .input_vector_i  (inr),
    .start_select_i  (selr),
    .output_vector_o (outr)
  );

  function automatic logic [15:0] rot4(input logic [15:0] v, input int s);
    logic [15:0] r;
    for (int j = 0; j < 4; j++) r[j*4 +: 4] = v[((s + j) % 4)*4 +: 4];
    return r;
  endfunction

  function automatic logic [11:0] rot3(input logic [11:0] v, input int s);
    logic [11:0] r;
    for (int j = 0; j < 3; j++) r[j*4 +: 4] = v[((s + j) % 3)*4 +: 4];
    return r;
  endfunction

  task automatic test_reset;
    #2 arst_n = 1'b0;
    inr  = 16'h4321;
    selr = 2'd1;
    #1;
    checks++;
    if (outr !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", outr, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      inr  = 16'h1111 * (i + 5);
      selr = 2'(i);
      checks++;
      if (outr !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold_%0d: got %h expected %h", i, outr, 16'h0);
      end
    end
  endtask

  task automatic test_rotate_pow2;
    logic [15:0] vin [8]  = '{16'hDCBA, 16'hDCBA, 16'hDCBA, 16'hDCBA,
                              16'h4321, 16'h4321, 16'h4321, 16'h4321};
    logic [1:0]  vsel [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] vexp [8] = '{16'hDCBA, 16'hADCB, 16'hBADC, 16'hCBAD,
                              16'h4321, 16'h1432, 16'h2143, 16'h3214};
    for (int i = 0; i < 8; i++) begin
      in4  = vin[i];
      sel4 = vsel[i];
      #1;
      checks++;
      if (out4 !== vexp[i]) begin
        errors++;
        $display("FAIL rot4_vec%0d sel=%0d: got %h expected %h", i, vsel[i], out4, vexp[i]);
      end
    end
  endtask

  task automatic test_non_pow2;
    logic [11:0] vin [5]  = '{12'h321, 12'h321, 12'h321, 12'h321, 12'hCBA};
    logic [1:0]  vsel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [11:0] vexp [5] = '{12'h321, 12'h132, 12'h213, 12'h321, 12'hACB};
    for (int i = 0; i < 5; i++) begin
      in3  = vin[i];
      sel3 = vsel[i];
      #1;
      checks++;
      if (out3 !== vexp[i]) begin
        errors++;
        $display("FAIL rot3_vec%0d sel=%0d: got %h expected %h", i, vsel[i], out3, vexp[i]);
      end
    end
  endtask

  task automatic test_reg_latency;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    inr    = 16'h4321;
    selr   = 2'd1;
    #1;
    checks++;
    if (outr !== 16'h0) begin
      errors++;
      $display("FAIL reg_before_edge: got %h expected %h", outr, 16'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outr !== 16'h1432) begin
      errors++;
      $display("FAIL reg_first_load: got %h expected %h", outr, 16'h1432);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vin [3]  = '{16'hDCBA, 16'h4321, 16'hDCBA};
    logic [1:0]  vsel [3] = '{2'd3, 2'd2, 2'd0};
    logic [15:0] vexp [3] = '{16'hCBAD, 16'h2143, 16'hDCBA};
    for (int i = 0; i < 3; i++) begin
      inr  = vin[i];
      selr = vsel[i];
      @(posedge clk);
      #1;
      checks++;
      if (outr !== vexp[i]) begin
        errors++;
        $display("FAIL reg_b2b_%0d: got %h expected %h", i, outr, vexp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    inr  = 16'hDCBA;
    selr = 2'd2;
    @(posedge clk);
    #1;
    checks++;
    if (outr !== 16'hBADC) begin
      errors++;
      $display("FAIL reg_pre_reset: got %h expected %h", outr, 16'hBADC);
    end
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (outr !== 16'h0) begin
      errors++;
      $display("FAIL reg_mid_reset: got %h expected %h", outr, 16'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outr !== 16'h0) begin
      errors++;
      $display("FAIL reg_mid_reset_hold: got %h expected %h", outr, 16'h0);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_random_soak;
    int          pass_cnt [4] = '{0, 0, 0, 0};
    logic [15:0] exp_r;
    logic [15:0] exp4;
    logic [11:0] exp3;
    exp_r = 16'h0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        checks++;
        if (outr !== exp_r) begin
          errors++;
          $display("FAIL soak_reg iter %0d: got %h expected %h", i, outr, exp_r);
        end
      end
      in4  = 16'($urandom);
      sel4 = 2'($urandom_range(0, 3));
      in3  = 12'($urandom);
      sel3 = 2'($urandom_range(0, 3));
      inr  = 16'($urandom);
      selr = 2'($urandom_range(0, 3));
      exp4  = rot4(in4, int'(sel4));
      exp3  = rot3(in3, int'(sel3));
      exp_r = rot4(inr, int'(selr));
      @(negedge clk);
      checks++;
      if (out4 !== exp4) begin
        errors++;
        $display("FAIL soak4 iter %0d in=%h sel=%0d: got %h expected %h", i, in4, sel4, out4, exp4);
      end else begin
        pass_cnt[sel4]++;
      end
      checks++;
      if (out3 !== exp3) begin
        errors++;
        $display("FAIL soak3 iter %0d in=%h sel=%0d: got %h expected %h", i, in3, sel3, out3, exp3);
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (pass_cnt[s] < 100) begin
        errors++;
        $display("FAIL soak4_coverage sel=%0d: got %0d passes expected >= 100", s, pass_cnt[s]);
      end
    end
  endtask

  initial begin
    in4  = '0;
    sel4 = '0;
    in3  = '0;
    sel3 = '0;
    inr  = '0;
    selr = '0;
    test_reset();
    test_rotate_pow2();
    test_non_pow2();
    test_reg_latency();
    test_back_to_back();
    test_reset_midstream();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
